// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencing controller for the HI/LO multiply/divide unit.
// It accepts one MULT/MULTU/DIV/DIVU request at a time. A multiply takes a
// single-cycle product stage. A divide runs a 32-step restoring divider.
// Results are committed to HI/LO together when the operation completes.
// A flush cancels in-flight work, so a flushed instruction never writes HI/LO.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_op is one-hot
//                        [0] mult, [1] multu, [2] div, [3] divu
//                        (multi-hot resolves with [0] > [1] > [2] > [3])
//   req_src1/req_src2    rs / rt operands
//   flush                cancels the operation in progress
//   wr_hi/wr_lo/wr_data  MTHI / MTLO writes
//   busy                 operation in progress
//   done                 one-cycle pulse: HI/LO hold the new result
//   hi/lo                architectural HI and LO registers
module muldiv_sched #(
    parameter logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF,
    parameter logic [31:0] HILO_RST   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        req_ready,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV_PREP, S_DIV_RUN, S_DIV_FIX, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] src1_q, src1_d, src2_q, src2_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
    logic        sgn_q, sgn_d;   // latched operation is signed
    logic        dz_q, dz_d;     // divisor was zero: result bypasses sign fix-up
    logic [4:0]  cnt_q, cnt_d;

    logic        accept, op_is_mul, op_signed;
    logic [31:0] abs1, abs2;
    logic [63:0] mag, prod;
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff, q_fix, r_fix;

    assign req_ready = (state_q == S_IDLE) & ~flush;
    assign accept    = req_valid & req_ready & (|req_op);
    assign op_is_mul = req_op[0] | req_op[1];
    // Signed when mult wins, or div wins (multu not present to outrank it).
    assign op_signed = req_op[0] | (req_op[2] & ~req_op[1]);

    // Magnitudes are used for signed ops. 0x8000_0000 maps to itself, which
    // is the correct unsigned magnitude.
    assign abs1 = (sgn_q & src1_q[31]) ? -src1_q : src1_q;
    assign abs2 = (sgn_q & src2_q[31]) ? -src2_q : src2_q;
    assign mag  = {32'b0, abs1} * {32'b0, abs2};
    assign prod = (sgn_q & (src1_q[31] ^ src2_q[31])) ? -mag : mag;

    // Restoring step. The shifted remainder can reach 33 bits. When the trial
    // subtraction succeeds, the result is below the divisor and fits in 32 bits.
    assign shifted = {rem_q, quot_q[31]};
    assign ge      = (shifted >= {1'b0, dvsr_q});
    assign diff    = shifted[31:0] - dvsr_q;

    assign q_fix = (sgn_q & ~dz_q & (src1_q[31] ^ src2_q[31])) ? -quot_q : quot_q;
    assign r_fix = (sgn_q & ~dz_q & src1_q[31]) ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        // A commit below overrides these MT writes.
        hi_d    = wr_hi ? wr_data : hi_q;
        lo_d    = wr_lo ? wr_data : lo_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        sgn_d   = sgn_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    src1_d  = req_src1;
                    src2_d  = req_src2;
                    sgn_d   = op_signed;
                    state_d = op_is_mul ? S_MUL : S_DIV_PREP;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    {hi_d, lo_d} = prod;
                    state_d      = S_DONE;
                end
            end
            S_DIV_PREP: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d  = 5'd0;
                    dvsr_d = abs2;
                    if (src2_q == 32'd0) begin
                        quot_d  = DIV_ZERO_Q;
                        rem_d   = src1_q;
                        dz_d    = 1'b1;
                        state_d = S_DIV_FIX;
                    end else begin
                        quot_d  = abs1;
                        rem_d   = 32'd0;
                        dz_d    = 1'b0;
                        state_d = S_DIV_RUN;
                    end
                end
            end
            S_DIV_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    quot_d = {quot_q[30:0], ge};
                    rem_d  = ge ? diff : shifted[31:0];
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DIV_FIX;
                    end
                end
            end
            S_DIV_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d    = r_fix;
                    lo_d    = q_fix;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            rem_q   <= 32'd0;
            quot_q  <= 32'd0;
            dvsr_q  <= 32'd0;
            sgn_q   <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            sgn_q   <= sgn_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_MUL) | (state_q == S_DIV_PREP) |
                  (state_q == S_DIV_RUN) | (state_q == S_DIV_FIX);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

    logic        clk = 1'b0;
    logic        resetn, req_valid, flush, wr_hi, wr_lo;
    logic [3:0]  req_op;
    logic [31:0] req_src1, req_src2, wr_data;
    logic        req_ready, busy, done;
    logic [31:0] hi, lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_sched dut (
        .clk      (clk),
        .resetn   (resetn),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_src1 (req_src1),
        .req_src2 (req_src2),
        .req_ready(req_ready),
        .flush    (flush),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: the architectural result and latency of one operation.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] ehi, output logic [31:0] elo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[0]) begin
            p = sa * sb;
            lat = 2;
        end else if (op[1]) begin
            p = {32'b0, a} * {32'b0, b};
            lat = 2;
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
            lat = 3;
        end else begin
            if (op[2]) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'({32'b0, a}) / longint'({32'b0, b});
                r = longint'({32'b0, a}) % longint'({32'b0, b});
            end
            p = {r[31:0], q[31:0]};
            lat = 35;
        end
        ehi = p[63:32];
        elo = p[31:0];
    endtask

    // Issue one operation, optionally with an MTLO write at cycle mt_cyc.
    // Checks the latency, the single done pulse, the busy length and HI/LO.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mt_cyc, input logic [31:0] mt_data);
        int          lat, done_cyc, done_cnt, busy_cnt;
        logic [31:0] ehi, elo;
        model(op, a, b, lat, ehi, elo);
        done_cyc = -1;
        done_cnt = 0;
        busy_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        #1 chk("ready_c0", 32'(req_ready), 32'd1);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            wr_lo     = (k == mt_cyc);
            wr_data   = mt_data;
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (done_cyc >= 0 && k > done_cyc) break;
        end
        wr_lo = 1'b0;
        chk("latency", 32'(done_cyc), 32'(lat));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(lat - 1));
        chk("hi", hi, ehi);
        chk("lo", lo, elo);
        $display("op=%b a=%h b=%h hi=%h lo=%h latency=%0d", op, a, b, hi, lo, done_cyc);
    endtask

    logic [31:0] snap_hi, snap_lo, r32, ehi, elo;
    int          dcnt, lat;

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_src1 = '0; req_src2 = '0;
        flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        resetn = 1'b1;

        // Multiply and divide directed cases.
        run_op(4'b0001, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFFA);
        run_op(4'b0010, 32'hFFFF_FFFE, 32'h0000_0003, 0, 0);
        chk("multu_hi_const", hi, 32'h0000_0002);
        run_op(4'b0100, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);
        run_op(4'b1000, 32'd100, 32'd7, 0, 0);
        run_op(4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("ovf_lo_const", lo, 32'h8000_0000);
        chk("ovf_hi_const", hi, 32'd0);
        run_op(4'b1000, 32'd5, 32'd0, 0, 0);
        chk("dz_lo_const", lo, 32'hFFFF_FFFF);
        run_op(4'b0100, 32'hFFFF_FFF9, 32'd0, 0, 0);
        run_op(4'b1100, 32'hFFFF_FFF9, 32'd2, 0, 0);   // multi-hot: div wins
        run_op(4'b0110, 32'hFFFF_FFFE, 32'd3, 0, 0);   // multi-hot: multu wins

        // An MTLO write in the divide commit cycle loses to the quotient.
        run_op(4'b1000, 32'd100, 32'd7, 34, 32'h0000_1234);
        chk("mt_vs_commit_lo", lo, 32'd14);

        // MTHI in IDLE, then MTHI+MTLO together.
        @(negedge clk); wr_hi = 1'b1; wr_data = 32'hCAFE_0001;
        @(negedge clk); wr_hi = 1'b0; #1;
        chk("mthi_idle", hi, 32'hCAFE_0001);
        @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0BAD_F00D;
        @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0; #1;
        chk("mt_both_hi", hi, 32'h0BAD_F00D);
        chk("mt_both_lo", lo, 32'h0BAD_F00D);
        $display("op=mt hi=%h lo=%h", hi, lo);

        // Flush at C20 of a divide.
        snap_hi = hi; snap_lo = lo; dcnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0100; req_src1 = 32'd1000; req_src2 = 32'd3;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = (k == 20);
            #1;
            if (done) dcnt++;
            if (k == 21) begin
                chk("flush_busy_c21", 32'(busy), 32'd0);
                chk("flush_ready_c21", 32'(req_ready), 32'd1);
            end
        end
        chk("flush_div_done", 32'(dcnt), 32'd0);
        chk("flush_div_hi", hi, snap_hi);
        chk("flush_div_lo", lo, snap_lo);
        $display("op=div_flush hi=%h lo=%h", hi, lo);

        // Flush during MUL.
        dcnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd1234; req_src2 = 32'd5678;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            flush = (k == 1);
            #1;
            if (done) dcnt++;
        end
        chk("flush_mul_done", 32'(dcnt), 32'd0);
        chk("flush_mul_hi", hi, snap_hi);
        chk("flush_mul_lo", lo, snap_lo);
        $display("op=mul_flush hi=%h lo=%h", hi, lo);

        // A request held high is re-accepted only once back in IDLE (C3).
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0010; req_src1 = 32'd7; req_src2 = 32'd9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            chk("hold_ready", 32'(req_ready), 32'(k == 3));
        end
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); #1;
        chk("hold_done_c5", 32'(done), 32'd1);
        chk("hold_lo", lo, 32'd63);
        $display("op=multu_held hi=%h lo=%h", hi, lo);

        // Asynchronous reset at C10 of a divide.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1000; req_src1 = 32'hFFFF_0000; req_src2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        $display("op=async_reset hi=%h lo=%h", hi, lo);
        @(negedge clk); resetn = 1'b1;
        run_op(4'b0001, 32'h8000_0000, 32'h8000_0000, 0, 0);

        // Randomized operations against the model.
        for (int n = 0; n < 16; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'b0001 << $urandom_range(0, 3);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b, 0, 0);
        end

        // Make sure model and bench agree on one spot value too.
        model(4'b1000, 32'd100, 32'd7, lat, ehi, elo);
        r32 = elo;
        chk("model_divu_spot", r32, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
